// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants, FSM states and command type for the grid move sequencer
package grid_pkg;

  // Direction encoding shared with the grid mover
  localparam logic [1:0] DIR_PX = 2'd0;
  localparam logic [1:0] DIR_NX = 2'd1;
  localparam logic [1:0] DIR_PY = 2'd2;
  localparam logic [1:0] DIR_NY = 2'd3;

  localparam int         GRID_MAX  = 15;
  // Largest step count the mover accepts in one request
  localparam logic [1:0] MAX_CHUNK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] dir;
    logic [3:0] len;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - single-clock command FIFO with full/empty flags
module cmd_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  // A pop only sees entries already stored, never one written this cycle
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - splits queued move commands into mover chunks and holds the clamped grid position
module move_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GRID_MAX   = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dir,
  input  logic [3:0] cmd_len,
  output logic       mv_valid,
  output logic [4:0] mv_x,
  output logic [4:0] mv_y,
  output logic [1:0] mv_steps,
  output logic [1:0] mv_dir,
  input  logic [4:0] fx,
  input  logic [4:0] fy,
  input  logic       res_valid,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       busy,
  output logic       done,
  output logic       wall_hit
);

  import grid_pkg::*;

  localparam logic [3:0] GMAX = 4'(GRID_MAX);

  state_e     state_q, state_d;
  logic [3:0] pos_x_q, pos_x_d;
  logic [3:0] pos_y_q, pos_y_d;
  logic [3:0] rem_len_q, rem_len_d;
  logic [1:0] cur_dir_q, cur_dir_d;
  logic [1:0] chunk_q, chunk_d;
  logic       done_q, done_d;
  logic       wall_hit_q, wall_hit_d;

  cmd_t       fifo_in, fifo_out;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0] step;
  logic [3:0] rem_nxt;
  logic [3:0] new_x, new_y;

  assign fifo_in   = '{dir: cmd_dir, len: cmd_len};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (fifo_push),
    .din  (fifo_in),
    .pop  (fifo_pop),
    .dout (fifo_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign done     = done_q;
  assign wall_hit = wall_hit_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  // Sequencer FSM: pop, issue one chunk, then absorb and clamp the mover result
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    rem_len_d  = rem_len_q;
    cur_dir_d  = cur_dir_q;
    chunk_d    = chunk_q;
    done_d     = 1'b0;
    wall_hit_d = 1'b0;
    fifo_pop   = 1'b0;
    mv_valid   = 1'b0;
    mv_x       = '0;
    mv_y       = '0;
    mv_steps   = '0;
    mv_dir     = '0;
    step       = (rem_len_q > {2'b00, MAX_CHUNK}) ? MAX_CHUNK : rem_len_q[1:0];
    rem_nxt    = rem_len_q;
    new_x      = pos_x_q;
    new_y      = pos_y_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rem_len_d = fifo_out.len;
          cur_dir_d = fifo_out.dir;
          // Zero-length commands complete without touching the mover
          if (fifo_out.len == 4'd0) done_d = 1'b1;
          else                      state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mv_valid = 1'b1;
        mv_steps = step;
        mv_dir   = cur_dir_q;
        mv_x     = {1'b0, pos_x_q};
        mv_y     = {1'b0, pos_y_q};
        chunk_d  = step;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (res_valid) begin
          // Out-of-range results pin to the wall in the direction of travel
          new_x = fx[4] ? ((cur_dir_q == DIR_PX) ? GMAX : 4'd0) : fx[3:0];
          new_y = fy[4] ? ((cur_dir_q == DIR_PY) ? GMAX : 4'd0) : fy[3:0];
          pos_x_d = new_x;
          pos_y_d = new_y;
          if (fx[4] || fy[4]) begin
            wall_hit_d = 1'b1;
            rem_nxt    = 4'd0;
          end else begin
            rem_nxt = rem_len_q - {2'b00, chunk_q};
          end
          rem_len_d = rem_nxt;
          if (rem_nxt == 4'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, position and pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      rem_len_q  <= '0;
      cur_dir_q  <= '0;
      chunk_q    <= '0;
      done_q     <= 1'b0;
      wall_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      rem_len_q  <= rem_len_d;
      cur_dir_q  <= cur_dir_d;
      chunk_q    <= chunk_d;
      done_q     <= done_d;
      wall_hit_q <= wall_hit_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scoreboard bench for move_sequencer with a behavioural grid mover
module tb_move_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;
  logic [3:0] cmd_len;
  logic       mv_valid;
  logic [4:0] mv_x, mv_y;
  logic [1:0] mv_steps, mv_dir;
  logic [4:0] fx, fy;
  logic       res_valid;
  logic [3:0] pos_x, pos_y;
  logic       busy, done, wall_hit;

  int passed = 0;
  int total  = 0;
  bit hold   = 1'b0;

  logic [13:0] mv_q[$];
  logic [9:0]  ev_q[$];

  always #5 clk = ~clk;

  move_sequencer #(.FIFO_DEPTH(4), .GRID_MAX(15)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_len  (cmd_len),
    .mv_valid (mv_valid),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .mv_steps (mv_steps),
    .mv_dir   (mv_dir),
    .fx       (fx),
    .fy       (fy),
    .res_valid(res_valid),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .busy     (busy),
    .done     (done),
    .wall_hit (wall_hit)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [13:0] mvv(input int x, input int y, input int s, input int d);
    return {5'(x), 5'(y), 2'(s), 2'(d)};
  endfunction

  function automatic logic [9:0] evv(input int dn, input int wh, input int x, input int y);
    return {1'(dn), 1'(wh), 4'(x), 4'(y)};
  endfunction

  // Monitor: every mover request and every done/wall_hit pulse is checked against the scoreboard
  always @(negedge clk) begin : monitor
    logic [13:0] em;
    logic [9:0]  ee;
    if (rstn) begin
      if (mv_valid) begin
        if (mv_q.size() == 0) chk("unexpected_mv_valid", 1, 0);
        else begin
          em = mv_q.pop_front();
          chk("mv_request", {mv_x, mv_y, mv_steps, mv_dir}, em);
        end
      end
      if (done || wall_hit) begin
        if (ev_q.size() == 0) chk("unexpected_done_or_wall", 1, 0);
        else begin
          ee = ev_q.pop_front();
          chk("completion_event", {done, wall_hit, pos_x, pos_y}, ee);
        end
      end
    end
  end

  // Grid mover model: answers one cycle after a request unless held off
  initial begin : mover
    logic [4:0] nx, ny;
    res_valid = 1'b0;
    fx = '0;
    fy = '0;
    forever begin
      @(negedge clk);
      if (mv_valid && rstn) begin
        nx = mv_x;
        ny = mv_y;
        case (mv_dir)
          2'd0: nx = mv_x + 5'(mv_steps);
          2'd1: nx = mv_x - 5'(mv_steps);
          2'd2: ny = mv_y + 5'(mv_steps);
          default: ny = mv_y - 5'(mv_steps);
        endcase
        while (hold) @(negedge clk);
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        fx = nx;
        fy = ny;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
      end
    end
  end

  task automatic offer(input logic [1:0] d, input logic [3:0] l, output bit acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_len   = l;
    acc       = cmd_ready;
  endtask

  task automatic push_cmd(input logic [1:0] d, input logic [3:0] l);
    bit a;
    offer(d, l, a);
    chk("cmd_ready_at_push", a, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int n;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir = '0;
    cmd_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {mv_valid, done, wall_hit}, 0);
    chk("rst_mv_bus", {mv_x, mv_y, mv_steps, mv_dir}, 0);
    chk("rst_pos", {pos_x, pos_y}, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    // Chunking: 7 steps +x -> 3,3,1
    mv_q.push_back(mvv(0, 0, 3, 0));
    mv_q.push_back(mvv(3, 0, 3, 0));
    mv_q.push_back(mvv(6, 0, 1, 0));
    ev_q.push_back(evv(1, 0, 7, 0));
    push_cmd(2'd0, 4'd7);
    wait_idle();
    chk("chunk_pos", {pos_x, pos_y}, {4'd7, 4'd0});

    // Move to (14,0)
    mv_q.push_back(mvv(7, 0, 3, 0));
    mv_q.push_back(mvv(10, 0, 3, 0));
    mv_q.push_back(mvv(13, 0, 1, 0));
    ev_q.push_back(evv(1, 0, 14, 0));
    push_cmd(2'd0, 4'd7);
    wait_idle();

    // +x wall: fx=17 clamps to 15, rest of command dropped
    mv_q.push_back(mvv(14, 0, 3, 0));
    ev_q.push_back(evv(1, 1, 15, 0));
    push_cmd(2'd0, 4'd5);
    wait_idle();
    chk("px_wall_pos", {pos_x, pos_y}, {4'd15, 4'd0});

    // Walk back to (0,0) then up to (0,2)
    mv_q.push_back(mvv(15, 0, 3, 1));
    mv_q.push_back(mvv(12, 0, 3, 1));
    mv_q.push_back(mvv(9, 0, 3, 1));
    mv_q.push_back(mvv(6, 0, 3, 1));
    mv_q.push_back(mvv(3, 0, 3, 1));
    ev_q.push_back(evv(1, 0, 0, 0));
    push_cmd(2'd1, 4'd15);
    wait_idle();
    mv_q.push_back(mvv(0, 0, 2, 2));
    ev_q.push_back(evv(1, 0, 0, 2));
    push_cmd(2'd2, 4'd2);
    wait_idle();

    // -y wall: 2-3 wraps with bit 4 set -> y clamps to 0
    mv_q.push_back(mvv(0, 2, 3, 3));
    ev_q.push_back(evv(1, 1, 0, 0));
    push_cmd(2'd3, 4'd3);
    wait_idle();
    chk("ny_wall_pos", {pos_x, pos_y}, {4'd0, 4'd0});

    // Zero-length command: done without any mover request
    ev_q.push_back(evv(1, 0, 0, 0));
    push_cmd(2'd0, 4'd0);
    wait_idle();

    // Backpressure: mover held, six offers of one +x step
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mv_q.push_back(mvv(i, 0, 1, 0));
      ev_q.push_back(evv(1, 0, i + 1, 0));
    end
    for (int i = 0; i < 6; i++) begin
      offer(2'd0, 4'd1, a);
      chk($sformatf("bp_offer%0d_ready", i + 1), a, (i < 5) ? 1 : 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_still_full", cmd_ready, 0);
    hold = 1'b0;
    n = 0;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ready_returns", cmd_ready, 1);
    wait_idle();
    chk("bp_final_pos", {pos_x, pos_y}, {4'd5, 4'd0});

    // Reach (5,5)
    mv_q.push_back(mvv(5, 0, 3, 2));
    mv_q.push_back(mvv(5, 3, 2, 2));
    ev_q.push_back(evv(1, 0, 5, 5));
    push_cmd(2'd2, 4'd5);
    wait_idle();

    // Reset while waiting for the mover
    hold = 1'b1;
    mv_q.push_back(mvv(5, 5, 3, 0));
    push_cmd(2'd0, 4'd3);
    n = 0;
    while (mv_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_request_seen", mv_q.size(), 0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_pos", {pos_x, pos_y}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    hold = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_res_ignored_pos", {pos_x, pos_y}, 0);
    chk("late_res_ignored_busy", busy, 0);

    chk("mv_scoreboard_drained", mv_q.size(), 0);
    chk("event_scoreboard_drained", ev_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Command sequencer that sits directly upstream of the grid mover (the `dir` stage) and closes its feedback loop. It accepts move commands of up to 15 steps through a valid/ready handshake and buffers them in a small FIFO. It splits each command into mover-sized chunks of 0–3 steps and presents the current position to the mover. It clamps the mover's result to the 16x16 grid and holds the authoritative (x,y) position.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of two and at least 2.
- `GRID_MAX`, default 15: highest legal coordinate; the clamp target on overflow.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: FIFO not full.
- `cmd_dir`  in  2: direction encoding: 0 = +x, 1 = −x, 2 = +y, 3 = −y.
- `cmd_len`  in  4: total steps, 0–15.
- `mv_valid`  out  1: one-cycle request to the mover.
- `mv_x`, `mv_y`  out  5 each: current position, zero-extended.
- `mv_steps`  out  2: chunk size.
- `mv_dir`  out  2: chunk direction.
- `fx`, `fy`  in  5 each: mover result. Bit 4 set means out of range.
- `res_valid`  in  1: `fx`/`fy` valid this cycle.
- `pos_x`, `pos_y`  out  4 each: registered position.
- `busy`  out  1: FSM not IDLE, or FIFO not empty.
- `done`  out  1: one-cycle pulse when a command completes.
- `wall_hit`  out  1: one-cycle pulse when a result was clamped.

## Operation
- **FIFO**
  - A push happens when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`; it is combinational from the FIFO count only.
  - A pop and a push in the same cycle are both allowed. A pop never sees an entry pushed in that same cycle.
- **FSM states: IDLE, ISSUE, WAIT.**
  - **IDLE**
    - If the FIFO is not empty: pop the entry, load `rem_len` and `cur_dir`.
    - If `cmd_len == 0`: stay in IDLE and pulse `done` next cycle. Otherwise go to ISSUE.
  - **ISSUE** (exactly one cycle)
    - `mv_valid = 1`.
    - `mv_steps = min(rem_len, 3)`, `mv_dir = cur_dir`, `mv_x/mv_y = pos`.
    - Latch the chunk size. Go to WAIT.
  - **WAIT**
    - Hold until `res_valid`; `res_valid` in any other state is ignored.
    - On `res_valid`:
      - X clamp: if `fx[4]`, `new_x = (cur_dir == 0) ? GRID_MAX : 0`; else `new_x = fx[3:0]`.
      - Y clamp: the same rule with `fy`, using `cur_dir == 2` for `GRID_MAX`.
      - Update `pos`.
      - If either axis clamped: pulse `wall_hit`, set `rem_len = 0`. The rest of the command is discarded.
      - Else: `rem_len -= chunk`.
      - If `rem_len` is now 0: pulse `done` and go to IDLE. Otherwise go to ISSUE.
- **Arithmetic:** `rem_len` is 4-bit unsigned and never underflows because chunk ≤ `rem_len`. `pos` is 4-bit and always in the range 0..`GRID_MAX`.

## Timing
- **Reset values:**
  - FIFO empty, `cmd_ready = 1`.
  - FSM in IDLE, `pos = (0,0)`, `rem_len = 0`.
  - `mv_valid`, `done`, `wall_hit`, `busy` = 0; `mv_*` buses = 0.
- **Latency** (mover answering one cycle after `mv_valid`):
  - Push at cycle N: pop at N+1, ISSUE at N+2, `res_valid` at N+3.
  - For a 1-chunk command, `done` and the new `pos` are visible at N+4.
  - Each extra chunk adds 2 cycles.
- **Pulse timing:** `done` and `wall_hit` are registered and high for exactly one cycle. They are coincident when a clamp ends a command.
- **Back-to-back commands:** the FSM returns to IDLE for one cycle between commands; this IDLE cycle is the pop cycle of the next command.
- **Reset mid-command:** all state is discarded immediately. A `res_valid` that arrives after reset release is ignored because the FSM is in IDLE.
- **Full FIFO:** `cmd_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after a pop.

## Structure
- **Shared package `grid_pkg`:**
  - Direction encoding constants `DIR_PX`, `DIR_NX`, `DIR_PY`, `DIR_NY`.
  - `GRID_MAX`, and a max chunk constant of 3.
  - FSM state enum.
  - A 6-bit command struct: `{dir, len}`.
- **Sub-module `cmd_fifo`:** synchronous single-clock FIFO, parameterized by width and depth, with full/empty outputs and asynchronous active-low reset.
- **Top level:** the FSM, the clamp logic and the position registers.

## Test plan
- **Chunking:** reset, push `dir = 0`, `len = 7`, mover model adds steps -> three `mv_valid` pulses with `mv_steps` 3, 3, 1; final `pos = (7,0)`; one `done`; no `wall_hit`.
- **+x wall clamp:** from `pos (14,0)`, push `dir = 0`, `len = 5` -> one `mv_valid` with steps 3, `fx = 17` -> `pos_x = 15`; `wall_hit` and `done` pulse together; no second `mv_valid`.
- **−y wall clamp:** from `pos (0,2)`, push `dir = 3`, `len = 3` -> `fy` returns out of range (bit 4 set) -> `pos_y = 0`; `wall_hit` pulses.
- **Zero-length command:** push `len = 0` -> `done` pulses with no `mv_valid`; `pos` unchanged.
- **Backpressure:** hold `res_valid` low, push continuously -> the first command is popped and 4 more are accepted; `cmd_ready = 0` on the 6th offer. Release `res_valid` -> `cmd_ready` returns to 1 after the next pop.
- **Reset mid-command:** assert `rstn = 0` during WAIT with `pos (5,5)` -> `pos = (0,0)`, FIFO empty and `busy = 0` immediately. A `res_valid` after release causes no change.
